// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI-mode-0 responder standing in for the 8-channel 12-bit A2D.
// The MOSI command of frame n selects a channel. The 12-bit value for that
// channel (fetched through chan_sel/chan_val) is shifted out on MISO during
// frame n+1, MSB first, zero-extended to FRAME_BITS.
module a2d_spi_resp #(
    parameter int FRAME_BITS = 16,
    parameter int CHNL_MSB   = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic [2:0]  chan_sel,
    input  logic [11:0] chan_val,
    output logic [2:0]  cmd_chnl,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [4:0] CNT_MAX   = 5'd31;
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    // Bit counter increment that sticks at its maximum, so an overlong frame
    // can never wrap back around to a count that looks like a good frame.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == CNT_MAX) ? v : v + 5'd1;
    endfunction

    // Synchronizer chains; the third SS_n/SCLK stage gives the edge detectors
    // a settled previous value to compare against.
    logic ss_s1_q, ss_s2_q, ss_s3_q;
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    // FSM and datapath state.
    state_t               state_q, state_d;
    logic [FRAME_BITS-1:0] tx_shft_q, tx_shft_d;
    // Only the low CHNL_MSB+1 command bits are kept: anything above the
    // channel field is shifted out and never needed.
    logic [CHNL_MSB:0]    rx_shft_q, rx_shft_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [2:0]           cmd_chnl_q, cmd_chnl_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 miso_q, miso_d;
    // Counts the clocks after reset until all three synchronizer stages hold
    // real input samples; until then the reset-time idle levels could fake
    // an SS_n fall when a frame was already in progress at reset.
    logic [1:0]           warm_q, warm_d;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_fall   =  ss_s3_q   & ~ss_s2_q;
    assign ss_rise   = ~ss_s3_q   &  ss_s2_q;
    assign sclk_rise = ~sclk_s3_q &  sclk_s2_q;
    assign sclk_fall =  sclk_s3_q & ~sclk_s2_q;

    assign MISO       = miso_q;
    assign cmd_chnl   = cmd_chnl_q;
    assign chan_sel   = cmd_chnl_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

    // Bring the asynchronous master signals into the clk domain at idle levels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_s3_q   <= 1'b1;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            ss_s1_q   <= SS_n;
            ss_s2_q   <= ss_s1_q;
            ss_s3_q   <= ss_s2_q;
            sclk_s1_q <= SCLK;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Next-state and datapath decisions for the frame FSM.
    always_comb begin
        state_d      = state_q;
        tx_shft_d    = tx_shft_q;
        rx_shft_d    = rx_shft_q;
        bit_cnt_d    = bit_cnt_q;
        cmd_chnl_d   = cmd_chnl_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        warm_d       = warm_q;

        if (warm_q != 2'd3) begin
            warm_d = warm_q + 2'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        // chan_val is captured only here; later changes
                        // belong to the next frame.
                        state_d   = SHIFT;
                        tx_shft_d = {{(FRAME_BITS-12){1'b0}}, chan_val};
                        bit_cnt_d = 5'd0;
                    end else if (!ss_s2_q) begin
                        // SS_n low without a seen fall: a frame began before
                        // reset, so sit it out.
                        state_d = WAIT_HI;
                    end
                end
                SHIFT: begin
                    // SS_n rise has priority; a coincident SCLK edge is dropped.
                    if (ss_rise) begin
                        state_d = DONE;
                    end else if (sclk_rise) begin
                        rx_shft_d = {rx_shft_q[CHNL_MSB-1:0], mosi_s2_q};
                        bit_cnt_d = sat_inc(bit_cnt_q);
                    end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
                        tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
                DONE: begin
                    if (bit_cnt_q == FRAME_CNT) begin
                        cmd_chnl_d   = rx_shft_q[CHNL_MSB -: 3];
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                WAIT_HI: begin
                    if (ss_s2_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // MISO is driven only while shifting, and registered so it never glitches.
        miso_d = (state_d == SHIFT) ? tx_shft_d[FRAME_BITS-1] : 1'b0;
    end

    // Register the FSM state, shift registers and all outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_shft_q    <= '0;
            rx_shft_q    <= '0;
            bit_cnt_q    <= 5'd0;
            cmd_chnl_q   <= 3'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            miso_q       <= 1'b0;
            warm_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            tx_shft_q    <= tx_shft_d;
            rx_shft_q    <= rx_shft_d;
            bit_cnt_q    <= bit_cnt_d;
            cmd_chnl_q   <= cmd_chnl_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            miso_q       <= miso_d;
            warm_q       <= warm_d;
        end
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: an SPI mode-0 master task drives frames, expected
// frame results are queued per frame, and a monitor checks every
// frame_done/frame_err pulse against the head of the queue.
`timescale 1ns/1ps
module tb_a2d_spi_resp;

    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [2:0]  chan_sel;
    logic [11:0] chan_val;
    logic [2:0]  cmd_chnl;
    logic        frame_done;
    logic        frame_err;

    logic [11:0] src [8];
    assign chan_val = src[chan_sel];

    always #5 clk = ~clk;

    a2d_spi_resp #(.FRAME_BITS(16), .CHNL_MSB(13)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SS_n       (SS_n),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .chan_sel   (chan_sel),
        .chan_val   (chan_val),
        .cmd_chnl   (cmd_chnl),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    typedef struct packed {
        logic        is_err;
        logic [2:0]  cmd;
        logic [15:0] miso;
        logic [15:0] mask;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_miss = 0;
    logic [15:0] last_miso = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic is_err, input logic [2:0] cmd,
                            input logic [15:0] miso, input logic [15:0] mask);
        exp_t e;
        e.is_err = is_err;
        e.cmd    = cmd;
        e.miso   = miso;
        e.mask   = mask;
        sb.push_back(e);
    endtask

    // Mode-0 master: set MOSI, raise SCLK and sample MISO, lower SCLK.
    // Optional hooks change a source value or pulse reset at a given bit.
    task automatic spi_frame(input logic [15:0] cmd, input int nbits,
                             input int chg_bit, input int chg_ch,
                             input logic [11:0] chg_val, input int rst_bit);
        logic [15:0] w;
        w = '0;
        SS_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) src[chg_ch] = chg_val;
            if (i == rst_bit) begin
                rst_n = 1'b0;
                wait_clk(2);
                rst_n = 1'b1;
            end
            MOSI = cmd[15-i];
            wait_clk(HALF);
            SCLK = 1'b1;
            w[15-i] = MISO;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
        wait_clk(HALF);
        last_miso = w;
        SS_n = 1'b1;
        wait_clk(HALF);
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (frame_done || frame_err)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected no pulse",
                         frame_done, frame_err);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {frame_err, frame_done}, mon_e.is_err ? 2'b10 : 2'b01);
                check("cmd_chnl", cmd_chnl, mon_e.cmd);
                check("chan_sel", chan_sel, mon_e.cmd);
                check("miso_word", last_miso & mon_e.mask, mon_e.miso & mon_e.mask);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] prev;
        for (int i = 0; i < 8; i++) src[i] = 12'h000;
        src[0] = 12'h123;
        src[5] = 12'hABC;

        // Reset state
        rst_n = 1'b0;
        wait_clk(4);
        check("rst_miso", MISO, 1'b0);
        check("rst_cmd_chnl", cmd_chnl, 3'd0);
        check("rst_chan_sel", chan_sel, 3'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        wait_clk(8);

        // First frame returns channel 0 and selects channel 5
        push_exp(1'b0, 3'd5, 16'h0123, 16'hFFFF);
        spi_frame(16'h2800, 16, -1, 0, 12'h000, -1);
        // Second frame returns channel 5, selects channel 0
        push_exp(1'b0, 3'd0, 16'h0ABC, 16'hFFFF);
        spi_frame(16'h0000, 16, -1, 0, 12'h000, -1);
        // Aborted after 9 bits: error, channel held
        push_exp(1'b1, 3'd0, 16'h0123, 16'hFF80);
        spi_frame(16'h3800, 9, -1, 0, 12'h000, -1);
        // Next full frame still returns channel 0
        push_exp(1'b0, 3'd3, 16'h0123, 16'hFFFF);
        spi_frame(16'h1800, 16, -1, 0, 12'h000, -1);

        // Channel sweep with source value ch*0x111
        for (int c = 0; c < 8; c++) src[c] = 12'(c * 12'h111);
        prev = 3'd3;
        for (int c = 0; c < 8; c++) begin
            push_exp(1'b0, 3'(c), {4'h0, 12'(prev * 12'h111)}, 16'hFFFF);
            spi_frame({2'b00, 3'(c), 11'h000}, 16, -1, 0, 12'h000, -1);
            prev = 3'(c);
        end
        push_exp(1'b0, 3'd0, 16'h0777, 16'hFFFF);
        spi_frame(16'h0000, 16, -1, 0, 12'h000, -1);

        // Reset mid-frame after 5 bits: rest of frame silent, no pulses
        src[0] = 12'h5A5;
        spi_frame(16'h1000, 16, -1, 0, 12'h000, 5);
        check("rst_mid_miso_tail", last_miso & 16'h07FF, 16'h0000);
        check("rst_mid_cmd_chnl", cmd_chnl, 3'd0);
        push_exp(1'b0, 3'd4, 16'h05A5, 16'hFFFF);
        spi_frame(16'h2000, 16, -1, 0, 12'h000, -1);

        // chan_val change mid-frame affects only the following frame
        src[4] = 12'h0FF;
        push_exp(1'b0, 3'd4, 16'h00FF, 16'hFFFF);
        spi_frame(16'h2000, 16, 8, 4, 12'hF00, -1);
        push_exp(1'b0, 3'd4, 16'h0F00, 16'hFFFF);
        spi_frame(16'h2000, 16, -1, 0, 12'h000, -1);

        wait_clk(20);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
